prau_issue_ctrl: RTL and testbench
==================================

# prau_issue_ctrl

Multi-outstanding issue/retire controller for the Posit and quiRe Arithmetic Unit. It replaces the single-instruction-in-flight control of the PRAU top level. Up to RES_DEPTH operations can be outstanding across the pipelined datapath. Results retire strictly in issue order through a result FIFO with valid/ready backpressure. It sits between the core-side request/response handshakes and the PRAU datapath units (comp, conv, quire, move), which it drives with registered operands and samples at fixed per-operator latencies.

## Interface
- XLEN, 64, operand/result width
- tag_t, logic, request tag type, returned unchanged with the result
- RES_DEPTH, 4, result FIFO depth and maximum outstanding operations; power of two, 2..16
- MAX_LAT, 15, largest per-operator latency; sizes the completion pipeline
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- operand_a_i, operand_b_i  in  XLEN  request operands
- operator_i  in  prau_op_e  request operator
- tag_i  in  tag_t  request tag
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request ready
- dp_valid_o  out  1  issue strobe to datapath, one cycle per operation
- dp_operand_a_o, dp_operand_b_o  out  XLEN  registered operands to datapath
- dp_operator_o  out  prau_op_e  registered operator to datapath
- dp_result_i  in  XLEN  datapath result, already muxed by operator class
- out_valid_o  out  1  response valid
- out_ready_i  in  1  response ready
- result_o  out  XLEN  response result
- tag_o  out  tag_t  response tag
- outstanding_o  out  $clog2(RES_DEPTH)+1  count of in-flight operations plus FIFO entries

## Operation
- **Latency lookup** L(op) uses prau_pkg constants:
  - PADD, PSUB: PADD_LATENCY
  - PMUL: PMUL_LATENCY
  - PDIV: PDIV_LATENCY
  - PSQRT: PSQRT_LATENCY
  - QROUND: QROUND_LATENCY
  - QMADD, QMSUB: QMADD_LATENCY
  - all others: 0
- **Acceptance** requires all of the following. in_ready_o is combinational from registered state only; in_valid_i does not affect it.
  1. Credit: outstanding_o < RES_DEPTH. A pop in the same cycle does not free credit.
  2. Order: 1+L(op) > tail_rem. tail_rem is the number of cycles until the most recently issued op completes, 0 if none.
  3. Structural: if op ∈ {PDIV, PSQRT}, no PDIV or PSQRT is in flight.
  4. Quire: if op ∈ {QMADD, QMSUB, QROUND}, no quire op with remaining latency > 0 is in flight.
- **Completion pipeline:** a MAX_LAT+1 entry shift structure carries {valid, tag}. Its head samples dp_result_i. At most one completion per cycle follows from rule 2.
- **Result FIFO:** RES_DEPTH entries of {result, tag}, read and written in order. It cannot overflow by construction. An overflow attempt is an assertion failure.
- **Reset values:** in_ready_o=1, dp_valid_o=0, dp_operand_*_o=0, dp_operator_o=NONE, out_valid_o=0, result_o=0, tag_o=0, outstanding_o=0, tail_rem=0, FIFO empty.
- **Reset mid-operation** discards all in-flight and buffered results. No response is emitted after reset release.

## Timing
- Request handshake in cycle t.
- Cycle t+1: dp_valid_o=1, with dp_* holding the captured request.
- dp_result_i is sampled at the end of cycle t+1+L.
- Entry becomes visible at the FIFO head in cycle t+2+L, and out_valid_o rises then.
- Back-to-back acceptance is allowed every cycle when the rules hold. Equal-latency ops form a full-throughput pipeline.
- dp_* hold their values when dp_valid_o=0. They are never cleared between issues.
- out_valid_o/result_o/tag_o are stable while out_valid_o=1 and out_ready_i=0.
- outstanding_o updates one cycle after each event. Accept and pop in the same cycle leave it unchanged.

## Configuration
- PRAU_RESULT_BYPASS_EN defined:
  - When the FIFO is empty and a completion occurs in cycle t+1+L, out_valid_o=1 in that same cycle, with result_o=dp_result_i.
  - If out_ready_i=1, the completion is not written to the FIFO.
  - Latency drops by one cycle.
- Undefined: all completions pass through the FIFO (t+2+L).

## Test plan
- **Reset:** rst_ni low for 3 cycles, inputs random -> all outputs at the reset values listed above. Assert rst_ni low mid-stream with 3 outstanding -> outstanding_o=0, no out_valid_o afterwards.
- **Single PADD:** a=0x40, b=0x40, tag=5, out_ready_i=1 -> dp_valid_o at t+1. out_valid_o at t+2+PADD_LATENCY with tag_o=5 and result_o = dp_result_i model value. Both one cycle earlier with PRAU_RESULT_BYPASS_EN.
- **Ordering stall:** PMUL (tag 1) then PSGNJ (tag 2) in consecutive cycles -> in_ready_o low until tail_rem < 1. Responses in tag order 1, 2.
- **Structural:** PDIV then PDIV -> second accepted only after the first completes. PDIV then PADD with PADD_LATENCY ≥ remaining -> PADD accepted next cycle.
- **Backpressure:** RES_DEPTH=4, 6 PADDs with out_ready_i=0 -> exactly 4 accepted, in_ready_o=0, outstanding_o=4. After out_ready_i=1 -> tags 0..5 in order, no loss or duplication.
- **Full throughput:** 16 PADDs with out_ready_i=1 -> one acceptance and one response per cycle in steady state, outstanding_o constant.

Source files
------------

// File: rtl/prau_issue_ctrl.sv
// prau_issue_ctrl: in-order multi-outstanding issue/retire control for the PRAU; response 2+L cycles after accept (1+L with PRAU_RESULT_BYPASS_EN).
// in_ready_o drops on credit, ordering, div/sqrt and quire hazards; the result FIFO holds responses while out_ready_i is low.
package prau_pkg;
  typedef enum logic [4:0] {
    NONE, PADD, PSUB, PMUL, PDIV, PSQRT, PSGNJ, PSGNJN, PMIN, PMAX,
    PCMP, PCVT, QMADD, QMSUB, QROUND, QCLR, QNEG, PMV
  } prau_op_e;

  localparam int unsigned PADD_LATENCY   = 1;
  localparam int unsigned PMUL_LATENCY   = 3;
  localparam int unsigned PDIV_LATENCY   = 10;
  localparam int unsigned PSQRT_LATENCY  = 12;
  localparam int unsigned QROUND_LATENCY = 2;
  localparam int unsigned QMADD_LATENCY  = 4;
endpackage

module prau_issue_ctrl
  import prau_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter type         tag_t     = logic,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned MAX_LAT   = 15
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [XLEN-1:0]                operand_a_i,
  input  logic [XLEN-1:0]                operand_b_i,
  input  prau_op_e                       operator_i,
  input  tag_t                           tag_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic                           dp_valid_o,
  output logic [XLEN-1:0]                dp_operand_a_o,
  output logic [XLEN-1:0]                dp_operand_b_o,
  output prau_op_e                       dp_operator_o,
  input  logic [XLEN-1:0]                dp_result_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [XLEN-1:0]                result_o,
  output tag_t                           tag_o,
  output logic [$clog2(RES_DEPTH):0]     outstanding_o
);
  localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
  localparam int unsigned PW = $clog2(RES_DEPTH);
  localparam int unsigned LW = $clog2(MAX_LAT + 1);

  function automatic logic [LW-1:0] lat_of(input prau_op_e op);
    case (op)
      PADD, PSUB:   return LW'(PADD_LATENCY);
      PMUL:         return LW'(PMUL_LATENCY);
      PDIV:         return LW'(PDIV_LATENCY);
      PSQRT:        return LW'(PSQRT_LATENCY);
      QROUND:       return LW'(QROUND_LATENCY);
      QMADD, QMSUB: return LW'(QMADD_LATENCY);
      default:      return '0;
    endcase
  endfunction

  logic              dp_valid_q, dp_valid_d;
  logic [XLEN-1:0]   dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  prau_op_e          dp_op_q, dp_op_d;
  logic [LW-1:0]     tail_rem_q, tail_rem_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;

  // Completion pipeline: slot k holds the op that completes k cycles from now.
  logic [MAX_LAT:0]  pv_q, pv_d, pd_q, pd_d, pq_q, pq_d;
  tag_t              pt_q [MAX_LAT+1];
  tag_t              pt_d [MAX_LAT+1];

  logic [XLEN-1:0]   mem_res_q [RES_DEPTH];
  tag_t              mem_tag_q [RES_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;

  logic [LW-1:0]     op_lat;
  logic              op_ds, op_quire, credit_ok, order_ok, ds_ok, quire_ok;
  logic              accept, pop, fifo_empty, fifo_wr, fifo_rd, comp;

  assign op_lat    = lat_of(operator_i);
  assign op_ds     = (operator_i == PDIV) || (operator_i == PSQRT);
  assign op_quire  = (operator_i == QMADD) || (operator_i == QMSUB) || (operator_i == QROUND);
  assign credit_ok = outstanding_q < CW'(RES_DEPTH);
  assign order_ok  = ({1'b0, op_lat} + (LW+1)'(1)) > {1'b0, tail_rem_q};
  assign ds_ok     = !op_ds || !(|(pv_q & pd_q));
  assign quire_ok  = !op_quire || !(|(pv_q[MAX_LAT:1] & pq_q[MAX_LAT:1]));
  assign in_ready_o = credit_ok && order_ok && ds_ok && quire_ok;
  assign accept     = in_valid_i && in_ready_o;

  assign comp       = pv_q[0];
  assign fifo_empty = (cnt_q == '0);

  always_comb begin
    out_valid_o = !fifo_empty;
    result_o    = mem_res_q[rd_ptr_q];
    tag_o       = mem_tag_q[rd_ptr_q];
    fifo_wr     = comp;
`ifdef PRAU_RESULT_BYPASS_EN
    if (fifo_empty && comp) begin
      out_valid_o = 1'b1;
      result_o    = dp_result_i;
      tag_o       = pt_q[0];
      fifo_wr     = !out_ready_i;
    end
`endif
  end

  assign pop     = out_valid_o && out_ready_i;
  assign fifo_rd = pop && !fifo_empty;

  always_comb begin
    pv_d = '0;
    pd_d = '0;
    pq_d = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      pv_d[k] = pv_q[k+1];
      pd_d[k] = pd_q[k+1];
      pq_d[k] = pq_q[k+1];
      pt_d[k] = pt_q[k+1];
    end
    pt_d[MAX_LAT] = '0;
    if (accept) begin
      pv_d[op_lat] = 1'b1;
      pd_d[op_lat] = op_ds;
      pq_d[op_lat] = op_quire;
      pt_d[op_lat] = tag_i;
    end
  end

  always_comb begin
    dp_valid_d    = accept;
    dp_a_d        = accept ? operand_a_i : dp_a_q;
    dp_b_d        = accept ? operand_b_i : dp_b_q;
    dp_op_d       = accept ? operator_i  : dp_op_q;
    tail_rem_d    = accept ? op_lat : ((tail_rem_q != '0) ? tail_rem_q - LW'(1) : '0);
    outstanding_d = outstanding_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dp_valid_q    <= 1'b0;
      dp_a_q        <= '0;
      dp_b_q        <= '0;
      dp_op_q       <= NONE;
      tail_rem_q    <= '0;
      outstanding_q <= '0;
      pv_q          <= '0;
      pd_q          <= '0;
      pq_q          <= '0;
      for (int k = 0; k <= MAX_LAT; k++) pt_q[k] <= '0;
    end else begin
      dp_valid_q    <= dp_valid_d;
      dp_a_q        <= dp_a_d;
      dp_b_q        <= dp_b_d;
      dp_op_q       <= dp_op_d;
      tail_rem_q    <= tail_rem_d;
      outstanding_q <= outstanding_d;
      pv_q          <= pv_d;
      pd_q          <= pd_d;
      pq_q          <= pq_d;
      for (int k = 0; k <= MAX_LAT; k++) pt_q[k] <= pt_d[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_res_q[i] <= '0;
        mem_tag_q[i] <= '0;
      end
    end else begin
      if (fifo_wr) begin
        mem_res_q[wr_ptr_q] <= dp_result_i;
        mem_tag_q[wr_ptr_q] <= pt_q[0];
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

  // Credit accounting keeps the FIFO from ever filling past RES_DEPTH.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fifo_wr && !fifo_rd && (cnt_q == CW'(RES_DEPTH))));

  assign dp_valid_o     = dp_valid_q;
  assign dp_operand_a_o = dp_a_q;
  assign dp_operand_b_o = dp_b_q;
  assign dp_operator_o  = dp_op_q;
  assign outstanding_o  = outstanding_q;

endmodule

// File: tb/tb_prau_issue_ctrl.sv
// Scoreboard bench for prau_issue_ctrl: a latency-accurate datapath model feeds dp_result_i, responses are matched in issue order.
module tb_prau_issue_ctrl;
  import prau_pkg::*;

  localparam int XLEN      = 64;
  localparam int RES_DEPTH = 4;
  typedef logic [3:0] tag_t;
`ifdef PRAU_RESULT_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic            clk_i, rst_ni;
  logic [XLEN-1:0] operand_a_i, operand_b_i, dp_operand_a_o, dp_operand_b_o, dp_result_i, result_o;
  prau_op_e        operator_i, dp_operator_o;
  tag_t            tag_i, tag_o;
  logic            in_valid_i, in_ready_o, dp_valid_o, out_valid_o, out_ready_i;
  logic [$clog2(RES_DEPTH):0] outstanding_o;

  prau_issue_ctrl #(.XLEN(XLEN), .tag_t(tag_t), .RES_DEPTH(RES_DEPTH), .MAX_LAT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operator_i(operator_i), .tag_i(tag_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .dp_valid_o(dp_valid_o), .dp_operand_a_o(dp_operand_a_o), .dp_operand_b_o(dp_operand_b_o),
    .dp_operator_o(dp_operator_o), .dp_result_i(dp_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o), .tag_o(tag_o),
    .outstanding_o(outstanding_o)
  );

  typedef struct { tag_t tag; logic [XLEN-1:0] res; } exp_t;
  exp_t            exp_q[$];
  int              pop_cyc_q[$];
  logic [XLEN-1:0] due [int];
  int              n_checks = 0, n_fail = 0, cyc = 0;

  function automatic int lat(input prau_op_e op);
    case (op)
      PADD, PSUB:   return PADD_LATENCY;
      PMUL:         return PMUL_LATENCY;
      PDIV:         return PDIV_LATENCY;
      PSQRT:        return PSQRT_LATENCY;
      QROUND:       return QROUND_LATENCY;
      QMADD, QMSUB: return QMADD_LATENCY;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input prau_op_e op);
    return (a + (b << 1)) ^ 64'(op);
  endfunction

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc = cyc + 1;

  // Datapath model: result of an op issued in cycle c appears on dp_result_i during cycle c+L.
  always @(posedge clk_i) begin
    #1;
    if (dp_valid_o) due[cyc + lat(dp_operator_o)] = model(dp_operand_a_o, dp_operand_b_o, dp_operator_o);
    if (due.exists(cyc)) begin
      dp_result_i = due[cyc];
      due.delete(cyc);
    end else begin
      dp_result_i = {$urandom, $urandom};
    end
  end

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        pop_cyc_q.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got tag %0d result %h, expected no response", tag_o, result_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (tag_o !== e.tag || result_o !== e.res) begin
            n_fail++;
            $display("FAIL sb_response: got tag %0d result %h, expected tag %0d result %h", tag_o, result_o, e.tag, e.res);
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        exp_t n;
        n.tag = tag_i;
        n.res = model(operand_a_i, operand_b_i, operator_i);
        exp_q.push_back(n);
      end
    end
  end

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input prau_op_e op, input tag_t t);
    operand_a_i = a; operand_b_i = b; operator_i = op; tag_i = t; in_valid_i = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the rising edge that completes the handshake.
  task automatic drive(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input prau_op_e op, input tag_t t, output int acc);
    bit done;
    done = 0;
    acc  = -1;
    present(a, b, op, t);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin done = 1; acc = cyc; end
      sync();
    end
    in_valid_i = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drive_timeout: tag %0d not accepted within 200 cycles", t);
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present({$urandom, $urandom}, {$urandom, $urandom}, prau_op_e'(5'($urandom_range(0, 17))), tag_t'($urandom));
      in_valid_i  = 1'($urandom);
      out_ready_i = 1'($urandom);
      @(negedge clk_i);
      n_checks += 8;
      if (in_ready_o !== 1'b1)     begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready_o); end
      if (dp_valid_o !== 1'b0)     begin n_fail++; $display("FAIL rst_dp_valid: got %b want 0", dp_valid_o); end
      if (dp_operand_a_o !== '0)   begin n_fail++; $display("FAIL rst_dp_a: got %h want 0", dp_operand_a_o); end
      if (dp_operand_b_o !== '0)   begin n_fail++; $display("FAIL rst_dp_b: got %h want 0", dp_operand_b_o); end
      if (dp_operator_o !== NONE)  begin n_fail++; $display("FAIL rst_dp_op: got %0d want %0d", int'(dp_operator_o), int'(NONE)); end
      if (out_valid_o !== 1'b0)    begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid_o); end
      if (result_o !== '0 || tag_o !== '0) begin n_fail++; $display("FAIL rst_result_tag: got %h/%0d want 0/0", result_o, tag_o); end
      if (outstanding_o !== '0)    begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding_o); end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    sync();
    rst_ni = 1'b1;
    sync();
  endtask

  task automatic test_single_padd();
    int t, exp_c;
    out_ready_i = 1'b1;
    drive(64'h40, 64'h40, PADD, 4'd5, t);
    exp_c = t + 2 + PADD_LATENCY - BYP;
    for (int c = t + 1; c <= exp_c; c++) begin
      @(negedge clk_i);
      if (c == t + 1) begin
        n_checks++;
        if (dp_valid_o !== 1'b1 || dp_operand_a_o !== 64'h40 || dp_operand_b_o !== 64'h40 || dp_operator_o !== PADD) begin
          n_fail++; $display("FAIL padd_issue: dp_valid %b a %h b %h op %0d", dp_valid_o, dp_operand_a_o, dp_operand_b_o, int'(dp_operator_o));
        end
      end
      if (c == t + 2) begin
        n_checks++;
        if (dp_valid_o !== 1'b0 || dp_operand_a_o !== 64'h40) begin
          n_fail++; $display("FAIL padd_dp_hold: dp_valid %b a %h, want 0 / 40", dp_valid_o, dp_operand_a_o);
        end
      end
      n_checks++;
      if (out_valid_o !== (c == exp_c)) begin
        n_fail++; $display("FAIL padd_out_timing: cycle t+%0d out_valid %b", c - t, out_valid_o);
      end
    end
    n_checks++;
    if (tag_o !== 4'd5 || result_o !== model(64'h40, 64'h40, PADD)) begin
      n_fail++; $display("FAIL padd_result: got tag %0d result %h want 5 / %h", tag_o, result_o, model(64'h40, 64'h40, PADD));
    end
    wait_empty();
    sync();
  endtask

  task automatic test_order_stall();
    int t1, t2;
    out_ready_i = 1'b1;
    drive(64'h11, 64'h22, PMUL, 4'd1, t1);
    drive(64'h33, 64'h44, PSGNJ, 4'd2, t2);
    n_checks++;
    if (t2 != t1 + 1 + PMUL_LATENCY) begin
      n_fail++; $display("FAIL order_accept: PSGNJ accepted at t+%0d want t+%0d", t2 - t1, 1 + PMUL_LATENCY);
    end
    wait_empty();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL order_drain: %0d responses missing, want 0", exp_q.size()); end
    sync();
  endtask

  task automatic test_structural();
    int t1, t2;
    out_ready_i = 1'b1;
    drive(64'h100, 64'h3, PDIV, 4'd3, t1);
    drive(64'h200, 64'h5, PDIV, 4'd4, t2);
    n_checks++;
    if (t2 != t1 + 2 + PDIV_LATENCY) begin
      n_fail++; $display("FAIL div_div_accept: second PDIV at t+%0d want t+%0d", t2 - t1, 2 + PDIV_LATENCY);
    end
    wait_empty();
    sync();
    drive(64'h300, 64'h7, PDIV, 4'd6, t1);
    drive(64'h9, 64'h9, PADD, 4'd7, t2);
    n_checks++;
    if (t2 != t1 + 1 + PDIV_LATENCY - PADD_LATENCY) begin
      n_fail++; $display("FAIL div_add_stall: PADD at t+%0d want t+%0d", t2 - t1, 1 + PDIV_LATENCY - PADD_LATENCY);
    end
    wait_empty();
    sync();
    drive(64'h400, 64'hB, PDIV, 4'd8, t1);
    repeat (PDIV_LATENCY - PADD_LATENCY) sync();
    drive(64'hA, 64'hA, PADD, 4'd9, t2);
    n_checks++;
    if (t2 != t1 + 1 + PDIV_LATENCY - PADD_LATENCY) begin
      n_fail++; $display("FAIL div_add_next: PADD at t+%0d want t+%0d", t2 - t1, 1 + PDIV_LATENCY - PADD_LATENCY);
    end
    wait_empty();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL struct_drain: %0d responses missing, want 0", exp_q.size()); end
    sync();
  endtask

  task automatic test_backpressure();
    int k, pops0;
    bit hs;
    k = 0;
    pops0 = pop_cyc_q.size();
    out_ready_i = 1'b0;
    present(64'd0, 64'd3, PADD, 4'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      hs = in_ready_o;
      sync();
      if (hs) begin k++; present(64'(k * 17), 64'(k + 3), PADD, tag_t'(k)); end
    end
    @(negedge clk_i);
    n_checks += 3;
    if (k != RES_DEPTH)               begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", k, RES_DEPTH); end
    if (in_ready_o !== 1'b0)          begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready_o); end
    if (outstanding_o !== RES_DEPTH)  begin n_fail++; $display("FAIL bp_outstanding: got %0d want %0d", outstanding_o, RES_DEPTH); end
    sync();
    out_ready_i = 1'b1;
    for (int c = 0; c < 100 && k < 6; c++) begin
      @(negedge clk_i);
      hs = in_ready_o;
      sync();
      if (hs) begin k++; if (k < 6) present(64'(k * 17), 64'(k + 3), PADD, tag_t'(k)); end
    end
    in_valid_i = 1'b0;
    wait_empty();
    n_checks++;
    if (pop_cyc_q.size() - pops0 != 6) begin
      n_fail++; $display("FAIL bp_responses: got %0d responses want 6", pop_cyc_q.size() - pops0);
    end
    sync();
  endtask

  task automatic test_throughput();
    int k, acc_q[$];
    bit hs;
    k = 0;
    pop_cyc_q.delete();
    out_ready_i = 1'b1;
    present(64'h1000, 64'h1, PADD, 4'd0);
    for (int c = 0; c < 100 && k < 16; c++) begin
      @(negedge clk_i);
      hs = in_ready_o;
      if (hs) begin
        acc_q.push_back(cyc);
        if (k >= 4) begin
          n_checks++;
          if (outstanding_o !== PADD_LATENCY + 2 - BYP) begin
            n_fail++; $display("FAIL tp_outstanding: op %0d got %0d want %0d", k, outstanding_o, PADD_LATENCY + 2 - BYP);
          end
        end
      end
      sync();
      if (hs) begin k++; if (k < 16) present(64'(32'h1000 + k), 64'(k), PADD, tag_t'(k)); end
    end
    in_valid_i = 1'b0;
    wait_empty();
    n_checks += 2;
    if (acc_q.size() != 16 || acc_q[acc_q.size()-1] - acc_q[0] != 15) begin
      n_fail++; $display("FAIL tp_accept_rate: %0d accepts, span %0d, want 16 over 15", acc_q.size(),
                         acc_q.size() ? acc_q[acc_q.size()-1] - acc_q[0] : -1);
    end
    if (pop_cyc_q.size() != 16 || pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[0] != 15) begin
      n_fail++; $display("FAIL tp_response_rate: %0d responses, span %0d, want 16 over 15", pop_cyc_q.size(),
                         pop_cyc_q.size() ? pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[0] : -1);
    end
    sync();
  endtask

  task automatic test_reset_mid();
    int t, seen;
    seen = 0;
    out_ready_i = 1'b0;
    drive(64'h5, 64'h6, PMUL, 4'd9, t);
    drive(64'h7, 64'h8, PMUL, 4'd10, t);
    drive(64'h9, 64'hA, PMUL, 4'd11, t);
    @(negedge clk_i);
    n_checks++;
    if (outstanding_o !== 3) begin n_fail++; $display("FAIL mid_outstanding_pre: got %0d want 3", outstanding_o); end
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks += 2;
    if (outstanding_o !== 0)  begin n_fail++; $display("FAIL mid_outstanding_rst: got %0d want 0", outstanding_o); end
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid_rst: got %b want 0", out_valid_o); end
    sync();
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (out_valid_o) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_no_response: %0d response cycles after reset, want 0", seen); end
    sync();
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    operand_a_i = '0; operand_b_i = '0; operator_i = NONE; tag_i = '0; dp_result_i = '0;
    test_reset();
    test_single_padd();
    test_order_stall();
    test_structural();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_drain: %0d responses outstanding, want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
